// File: rtl/serial_addsub_pw.sv
`default_nettype none
// ============================================================================
// serial_addsub_pw : digit-serial add/subtract (DIGIT bits per clock) with
// start/busy/done handshake. Optional clamp-on-overflow via SERADD_SAT_EN.
// Rev 1.0
// ============================================================================
module serial_addsub_pw #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_cfg_err
      $error("serial_addsub_pw: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             done_q, done_d, sat_q, sat_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]       w_dsum;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]     w_res_next, w_result;
  logic                 w_last, w_cmsb, w_ovf;

  always_comb begin
    w_dsum     = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
    w_res_cat  = {w_dsum[DIGIT-1:0], res_q};
    w_res_next = WIDTH'(w_res_cat >> DIGIT);
    w_last     = (cnt_q == CW'(N - 1));
    // On the final digit the top bits of the shifters are the operand MSBs,
    // so the carry into the MSB falls out of the sum bit's XOR identity.
    w_cmsb     = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ w_dsum[DIGIT-1];
    w_ovf      = w_cmsb ^ w_dsum[DIGIT];
`ifdef SERADD_SAT_EN
    if (sat_q && w_ovf) begin
      w_result = a_sh_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_result = w_res_next;
    end
`else
    w_result = w_res_next;
`endif
  end

`ifndef SERADD_SAT_EN
  logic unused_sat_q;
  assign unused_sat_q = sat_q;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sat_d   = sat;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        res_d   = w_res_next;
        carry_d = w_dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (w_last) begin
          sum_d   = w_result;
          cout_d  = w_dsum[DIGIT];
          ovf_d   = w_ovf;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_pw.sv
`default_nettype none
// ============================================================================
// tb_serial_addsub_pw : directed checks of serial_addsub_pw at 8x1 and 32x4.
// Rev 1.0
// ============================================================================
module tb_serial_addsub_pw;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic [31:0] a, b;
  logic        sub, cin, sat;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serial_addsub_pw #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .cin(cin), .sat(sat), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub_pw #(.WIDTH(32), .DIGIT(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a), .b(b),
    .sub(sub), .cin(cin), .sat(sat), .busy(busy32), .done(done32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

`ifdef SERADD_SAT_EN
  localparam logic [31:0] c_sat_pos = 32'h7F;
  localparam logic [31:0] c_sat_neg = 32'h80;
`else
  localparam logic [31:0] c_sat_pos = 32'h80;
  localparam logic [31:0] c_sat_neg = 32'h00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a falling edge; the start is accepted at the next rising edge.
  task automatic run(input string tag, input bit wide,
                     input logic [31:0] ia, input logic [31:0] ib,
                     input logic isub, input logic icin, input logic isat,
                     input logic [31:0] es, input logic ec, input logic eo,
                     input int elat, input int poke);
    int cyc;
    int bad_hs;
    a = ia; b = ib; sub = isub; cin = icin; sat = isat;
    if (wide) start32 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    check({tag, "_busy"}, wide ? busy32 : busy8, 1);
    check({tag, "_done_lo"}, wide ? done32 : done8, 0);
    cyc = 0;
    bad_hs = 0;
    while (!(wide ? done32 : done8) && cyc < 40) begin
      if (!(wide ? busy32 : busy8)) bad_hs++;
      if (poke > 0 && cyc == poke) begin
        a = ~ia; b = ~ib; sub = ~isub;
        if (wide) start32 = 1'b1; else start8 = 1'b1;
      end else begin
        start8 = 1'b0; start32 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, elat);
    check({tag, "_busy_gap"}, bad_hs, 0);
    check({tag, "_busy_at_done"}, wide ? busy32 : busy8, 0);
    check({tag, "_sum"}, wide ? sum32 : {24'h0, sum8}, es);
    check({tag, "_cout"}, wide ? cout32 : cout8, ec);
    check({tag, "_ovf"}, wide ? ovf32 : ovf8, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1; start8 = 1'b1; start32 = 1'b0;
    a = 32'h35; b = 32'h4A; sub = 1'b0; cin = 1'b0; sat = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_busy32", busy32, 0);
    check("rst_sum32", sum32, 0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", busy8, 0);

    run("add",     0, 32'h35, 32'h4A, 0, 0, 0, 32'h7F, 0, 0, 8, 0);
    run("wrap",    0, 32'hFF, 32'h01, 0, 0, 0, 32'h00, 1, 0, 8, 0);
    run("ovf",     0, 32'h7F, 32'h01, 0, 0, 0, 32'h80, 0, 1, 8, 0);
    run("sat_pos", 0, 32'h7F, 32'h01, 0, 0, 1, c_sat_pos, 0, 1, 8, 0);
    run("sat_neg", 0, 32'h80, 32'h80, 0, 0, 1, c_sat_neg, 1, 1, 8, 0);
    run("cin",     0, 32'h10, 32'h20, 0, 1, 0, 32'h31, 0, 0, 8, 0);
    run("sub_neg", 0, 32'h10, 32'h20, 1, 0, 0, 32'hF0, 0, 0, 8, 0);
    run("sub_ovf", 0, 32'h80, 32'h01, 1, 1, 0, 32'h7F, 1, 1, 8, 0);

    // Abort after three RUN edges; outputs were 7F/1/1 beforehand.
    a = 32'h35; b = 32'h4A; sub = 1'b0; cin = 1'b0; sat = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    check("abort_ovf", ovf8, 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);

    run("after_rst", 0, 32'h35, 32'h4A, 0, 0, 0, 32'h7F, 0, 0, 8, 0);
    run("ignore",    0, 32'h12, 32'h34, 0, 0, 0, 32'h46, 0, 0, 8, 3);

    run("w32",      1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0, 32'h0000_0001, 1, 0, 8, 0);
    run("w32_b2b",  1, 32'h1234_5678, 32'h1111_1111, 1, 0, 0, 32'h0123_4567, 1, 0, 8, 0);
    run("w32_ovf",  1, 32'h8000_0000, 32'h0000_0001, 1, 0, 0, 32'h7FFF_FFFF, 1, 1, 8, 0);

    @(negedge clk);
    check("done_pulse_end", done32, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
